// File: rtl/dht11_receiver.sv
// DHT11 single-wire frame receiver: synchronizes the data line, decodes 40 bits by high-phase length.
// Optional checksum checking compiled in with `define DHT11_CHECKSUM_EN.
module dht11_receiver #(
  parameter int BIT1_THRESH = 3,
  parameter int TIMEOUT     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dht_in,
  output logic [7:0] humidity_int,
  output logic [7:0] humidity_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       data_valid,
  output logic       checksum_err,
  output logic       timeout_err,
  output logic       busy
);

  // state     | meaning
  // IDLE      | waiting for start
  // WAIT_RESP | start seen, waiting for sensor to pull the line low
  // RESP_LOW  | sensor response low phase
  // RESP_HIGH | sensor response high phase
  // BIT_LOW   | low preamble of a data bit
  // BIT_HIGH  | high phase of a data bit, length sets the bit value
  // CHECK     | one cycle: verify checksum and publish
  typedef enum logic [2:0] {
    IDLE, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic          sync1, sync2, din_prev;
  logic [CW-1:0] phase_cnt, high_cnt;
  logic [5:0]    bit_cnt;
  logic [39:0]   shift_reg;
  logic          rise, fall, phase_to, bit_val;

  assign rise     = sync2 & ~din_prev;
  assign fall     = ~sync2 & din_prev;
  assign phase_to = (phase_cnt == CW'(TIMEOUT));
  assign bit_val  = (high_cnt >= CW'(BIT1_THRESH));

`ifdef DHT11_CHECKSUM_EN
  logic [7:0] sum;
  assign sum = shift_reg[39:32] + shift_reg[31:24] + shift_reg[23:16] + shift_reg[15:8];
`else
  logic chk_byte_unused;
  assign chk_byte_unused = ^shift_reg[7:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      din_prev     <= 1'b1;
      phase_cnt    <= '0;
      high_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      humidity_int <= 8'h00;
      humidity_dec <= 8'h00;
      temp_int     <= 8'h00;
      temp_dec     <= 8'h00;
      data_valid   <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sync1        <= dht_in;
      sync2        <= sync1;
      din_prev     <= sync2;
      data_valid   <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
      phase_cnt    <= phase_cnt + CW'(1);

      // A stuck phase aborts the frame without touching the published data.
      if (state != IDLE && state != CHECK && phase_to) begin
        state       <= IDLE;
        busy        <= 1'b0;
        timeout_err <= 1'b1;
        phase_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            phase_cnt <= '0;
            if (start) begin
              state   <= WAIT_RESP;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          WAIT_RESP: if (!sync2) begin state <= RESP_LOW;  phase_cnt <= '0; end
          RESP_LOW:  if (rise)   begin state <= RESP_HIGH; phase_cnt <= '0; end
          RESP_HIGH: if (fall)   begin state <= BIT_LOW;   phase_cnt <= '0; end
          BIT_LOW: begin
            if (rise) begin
              state     <= BIT_HIGH;
              phase_cnt <= '0;
              high_cnt  <= CW'(1);  // the sample that showed the edge is already high
            end
          end
          BIT_HIGH: begin
            if (fall) begin
              shift_reg <= {shift_reg[38:0], bit_val};
              phase_cnt <= '0;
              if (bit_cnt == 6'd39) begin
                state <= CHECK;
              end else begin
                state   <= BIT_LOW;
                bit_cnt <= bit_cnt + 6'd1;
              end
            end else if (high_cnt != CW'(TIMEOUT)) begin
              high_cnt <= high_cnt + CW'(1);
            end
          end
          CHECK: begin
            phase_cnt <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
`ifdef DHT11_CHECKSUM_EN
            if (sum == shift_reg[7:0]) begin
              humidity_int <= shift_reg[39:32];
              humidity_dec <= shift_reg[31:24];
              temp_int     <= shift_reg[23:16];
              temp_dec     <= shift_reg[15:8];
              data_valid   <= 1'b1;
            end else begin
              checksum_err <= 1'b1;
            end
`else
            humidity_int <= shift_reg[39:32];
            humidity_dec <= shift_reg[31:24];
            temp_int     <= shift_reg[23:16];
            temp_dec     <= shift_reg[15:8];
            data_valid   <= 1'b1;
`endif
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht11_receiver.sv
// Self-checking bench for dht11_receiver: modelled sensor frames with randomized bit timing
// checked against a duration-based decode model.
module tb_dht11_receiver;
  localparam int THRESH = 3;
  localparam int TMO    = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       dht_in = 1'b1;
  logic [7:0] humidity_int, humidity_dec, temp_int, temp_dec;
  logic       data_valid, checksum_err, timeout_err, busy;

  dht11_receiver #(.BIT1_THRESH(THRESH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .dht_in(dht_in),
    .humidity_int(humidity_int), .humidity_dec(humidity_dec),
    .temp_int(temp_int), .temp_dec(temp_dec),
    .data_valid(data_valid), .checksum_err(checksum_err),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dv_tot = 0, ce_tot = 0, te_tot = 0, excl_viol = 0;
  int dur[40];
  logic [7:0] exp_hi = 8'h00, exp_hd = 8'h00, exp_ti = 8'h00, exp_td = 8'h00;

  always @(negedge clk) begin
    if (data_valid === 1'b1) dv_tot++;
    if (checksum_err === 1'b1) ce_tot++;
    if (timeout_err === 1'b1) te_tot++;
    if (int'(data_valid) + int'(checksum_err) + int'(timeout_err) > 1) excl_viol++;
  end

  task automatic hold(input logic v, input int n);
    dht_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_frame(input logic [39:0] bits, input int d0, input int d1, input bit rnd);
    for (int i = 0; i < 40; i++) begin
      if (bits[39-i]) dur[i] = rnd ? int'($urandom_range(3, 6)) : d1;
      else            dur[i] = rnd ? int'($urandom_range(1, 2)) : d0;
    end
  endtask

  // Sends the frame in dur[]; optionally pulses start at bit start_at or resets at bit abort_at.
  task automatic run_frame(input string tag, input int start_at, input int abort_at);
    int dv0, ce0, te0, waited;
    int b[5];
    bit load, aborted;
    dv0 = dv_tot; ce0 = ce_tot; te0 = te_tot;
    aborted = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hold(1'b0, 3);
    hold(1'b1, 3);
    for (int i = 0; i < 40; i++) begin
      if (i == abort_at) begin
        dht_in = 1'b1; rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (i == 10) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy mid-frame got %b want 1", tag, busy); end
      end
      if (i == start_at) begin
        dht_in = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        hold(1'b0, 2);
      end else begin
        hold(1'b0, 3);
      end
      hold(1'b1, dur[i]);
    end
    if (!aborted) hold(1'b0, 3);
    dht_in = 1'b1;
    waited = 0;
    while (busy !== 1'b0 && waited < 40) begin @(negedge clk); waited++; end
    repeat (3) @(negedge clk);
    checks++;
    if (waited >= 40) begin errors++; $display("FAIL %s busy stuck got %b want 0", tag, busy); end

    // Reference decode: a bit is 1 when its high phase lasted at least THRESH cycles.
    for (int k = 0; k < 5; k++) b[k] = 0;
    for (int i = 0; i < 40; i++)
      if (dur[i] >= THRESH) b[i/8] += 1 << (7 - i%8);
`ifdef DHT11_CHECKSUM_EN
    load = ((b[0] + b[1] + b[2] + b[3]) % 256) == b[4];
`else
    load = 1'b1;
`endif
    if (aborted) begin
      load = 1'b0;
      exp_hi = 8'h00; exp_hd = 8'h00; exp_ti = 8'h00; exp_td = 8'h00;
    end else if (load) begin
      exp_hi = 8'(b[0]); exp_hd = 8'(b[1]); exp_ti = 8'(b[2]); exp_td = 8'(b[3]);
    end

    checks++;
    if (dv_tot - dv0 != (!aborted && load ? 1 : 0)) begin
      errors++; $display("FAIL %s data_valid pulses got %0d want %0d", tag, dv_tot - dv0, (!aborted && load) ? 1 : 0);
    end
    checks++;
    if (ce_tot - ce0 != (!aborted && !load ? 1 : 0)) begin
      errors++; $display("FAIL %s checksum_err pulses got %0d want %0d", tag, ce_tot - ce0, (!aborted && !load) ? 1 : 0);
    end
    checks++;
    if (te_tot - te0 != 0) begin errors++; $display("FAIL %s timeout_err pulses got %0d want 0", tag, te_tot - te0); end
    checks++;
    if ({humidity_int, humidity_dec, temp_int, temp_dec} !== {exp_hi, exp_hd, exp_ti, exp_td}) begin
      errors++;
      $display("FAIL %s outputs got %h %h %h %h want %h %h %h %h", tag, humidity_int, humidity_dec,
               temp_int, temp_dec, exp_hi, exp_hd, exp_ti, exp_td);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({humidity_int, humidity_dec, temp_int, temp_dec} !== 32'h0) begin
      errors++; $display("FAIL reset outputs got %h%h%h%h want 00000000", humidity_int, humidity_dec, temp_int, temp_dec);
    end
    checks++;
    if ({data_valid, checksum_err, timeout_err, busy} !== 4'b0) begin
      errors++; $display("FAIL reset flags got %b%b%b%b want 0000", data_valid, checksum_err, timeout_err, busy);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    set_frame(40'h37_00_19_00_50, 1, 4, 1'b0);
    run_frame("good_frame", -1, -1);
    checks++;
    if (humidity_int !== 8'd55 || temp_int !== 8'd25) begin
      errors++; $display("FAIL good_frame values got hum=%0d temp=%0d want hum=55 temp=25", humidity_int, temp_int);
    end
  endtask

  task automatic test_bad_checksum();
    set_frame(40'h37_00_19_00_51, 1, 4, 1'b0);
    run_frame("bad_checksum", -1, -1);
  endtask

  task automatic test_timeout();
    int te0, k, seen;
    te0 = te_tot; seen = 0;
    dht_in = 1'b1;
    @(negedge clk); start = 1'b1;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (timeout_err === 1'b1) begin seen = k; break; end
    end
    // start sampled at the next edge; the phase counter then needs TMO more edges to reach TMO.
    checks++;
    if (seen != TMO + 2) begin errors++; $display("FAIL timeout latency got %0d want %0d", seen, TMO + 2); end
    repeat (3) @(negedge clk);
    checks++;
    if (te_tot - te0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout pulses/busy got %0d/%b want 1/0", te_tot - te0, busy);
    end
    checks++;
    if ({humidity_int, humidity_dec, temp_int, temp_dec} !== {exp_hi, exp_hd, exp_ti, exp_td}) begin
      errors++; $display("FAIL timeout outputs got %h%h%h%h want %h%h%h%h", humidity_int, humidity_dec,
                         temp_int, temp_dec, exp_hi, exp_hd, exp_ti, exp_td);
    end
  endtask

  task automatic test_threshold();
    set_frame(40'h00_00_00_01_01, 2, 3, 1'b0);
    run_frame("threshold", -1, -1);
    checks++;
    if (temp_dec !== 8'd1) begin errors++; $display("FAIL threshold temp_dec got %0d want 1", temp_dec); end
  endtask

  task automatic test_reset_mid_frame();
    set_frame(40'h41_02_17_05_5F, 1, 4, 1'b0);
    run_frame("reset_mid_frame", -1, 20);
    set_frame(40'h2A_01_16_03_44, 1, 4, 1'b0);
    run_frame("after_reset", -1, -1);
  endtask

  task automatic test_start_while_busy();
    logic [31:0] d;
    d = $urandom;
    set_frame({d, 8'(d[31:24] + d[23:16] + d[15:8] + d[7:0])}, 0, 0, 1'b1);
    run_frame("start_while_busy", 5, -1);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0]  ck;
    for (int n = 0; n < 6; n++) begin
      d  = $urandom;
      ck = d[31:24] + d[23:16] + d[15:8] + d[7:0];
      if (n % 2 == 1) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      set_frame({d, ck}, 0, 0, 1'b1);
      run_frame("random", -1, -1);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (excl_viol != 0) begin errors++; $display("FAIL exclusive pulses got %0d overlaps want 0", excl_viol); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_threshold();
    test_reset_mid_frame();
    test_start_while_busy();
    test_random();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dht11_receiver.md
DHT11_RECEIVER -- requirements
Module: dht11_receiver

Interface
REQ-001 Parameter BIT1_THRESH, default 3: high-phase length in clk cycles at or above which a data bit decodes as 1.
REQ-002 Parameter TIMEOUT, default 10: maximum clk cycles any single protocol phase may last before abort.
REQ-003 Port clk  input  1  system clock; the default parameters assume a 20 us period.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port start  input  1  host start done; driven from the start generator's confirm_to_reciver; sampled as a level.
REQ-006 Port dht_in  input  1  DHT11 data line as seen by the FPGA; asynchronous.
REQ-007 Port humidity_int  output  8  humidity integer byte.
REQ-008 Port humidity_dec  output  8  humidity decimal byte.
REQ-009 Port temp_int  output  8  temperature integer byte.
REQ-010 Port temp_dec  output  8  temperature decimal byte.
REQ-011 Port data_valid  output  1  one-cycle pulse when the data outputs are updated.
REQ-012 Port checksum_err  output  1  one-cycle pulse on checksum mismatch.
REQ-013 Port timeout_err  output  1  one-cycle pulse on phase timeout.
REQ-014 Port busy  output  1  high in every state except IDLE.

Function
REQ-015 dht_in SHALL pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized signal.
REQ-016 FSM states SHALL be IDLE, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH and CHECK.
REQ-017 IDLE SHALL go to WAIT_RESP when start=1.
REQ-018 WAIT_RESP SHALL go to RESP_LOW on the first synchronized low.
REQ-019 RESP_LOW SHALL go to RESP_HIGH on a rising edge.
REQ-020 RESP_HIGH SHALL go to BIT_LOW on a falling edge.
REQ-021 BIT_LOW SHALL go to BIT_HIGH on a rising edge.
REQ-022 BIT_HIGH SHALL count high cycles.
REQ-023 On the falling edge ending BIT_HIGH, the receiver SHALL shift bit = (high_cnt >= BIT1_THRESH) into a 40-bit register, MSB first, then go to BIT_LOW, or to CHECK after bit 39.
REQ-024 A phase counter SHALL clear on each state change.
REQ-025 If the phase counter reaches TIMEOUT in any state except IDLE and CHECK, the receiver SHALL pulse timeout_err, go to IDLE, and leave the outputs unchanged.
REQ-026 CHECK SHALL last one cycle and compare (byte0+byte1+byte2+byte3) mod 256 with byte4.
REQ-027 On a match, CHECK SHALL load the four data outputs from bytes 0..3 and pulse data_valid in the same cycle as the load.
REQ-028 On a mismatch, CHECK SHALL pulse checksum_err and leave the outputs unchanged.
REQ-029 CHECK SHALL then go to IDLE.
REQ-030 The bit counter SHALL run 0..39 and clear on entry to WAIT_RESP.
REQ-031 A high-phase counter SHALL saturate at TIMEOUT and never wrap.
REQ-032 start asserted while busy=1 SHALL be ignored.
REQ-033 If start is still high on return to IDLE, a new frame SHALL begin on the next cycle.
REQ-034 data_valid, checksum_err and timeout_err SHALL be mutually exclusive in every cycle.

Reset
REQ-035 rst=0 at a clk edge SHALL force state IDLE and set all counters and the shift register to 0.
REQ-036 Reset SHALL set all data outputs to 8'h00, set data_valid, checksum_err, timeout_err and busy to 0, and set both synchronizer flops to 1.
REQ-037 Reset mid-frame SHALL discard the partial frame and produce no pulses.

Configuration
REQ-038 Macro DHT11_CHECKSUM_EN SHALL select whether checksum checking is compiled in.
REQ-039 With DHT11_CHECKSUM_EN defined, CHECK SHALL behave as REQ-026 to REQ-028.
REQ-040 Without DHT11_CHECKSUM_EN, CHECK SHALL always load the outputs and pulse data_valid, and checksum_err SHALL be tied to 0.

Verification
REQ-041 Good frame: start=1, then a modelled sensor sends 37 00 19 00 50 (bit 0 = 1 cycle high, bit 1 = 4 cycles high) -> humidity_int=55, temp_int=25, decimals 0, exactly one data_valid pulse, busy back to 0.
REQ-042 Bad checksum: same frame with last byte 51 -> one checksum_err pulse, outputs keep their prior values, no data_valid; with the macro undefined, data_valid instead.
REQ-043 Timeout: start=1 with dht_in held high for 12 cycles -> timeout_err pulse at phase count 10, state IDLE, outputs unchanged.
REQ-044 Threshold boundary: bits with high phase of 2 cycles decode as 0 and 3 cycles as 1 -> frame 00 00 00 01 01 yields temp_dec=1 and data_valid.
REQ-045 Reset mid-frame: rst=0 for one cycle during bit 20 -> IDLE, no pulses; a following good frame decodes correctly.
REQ-046 Start while busy: pulse start again during bit 5 -> no restart, frame completes normally.
